// File: rtl/ysyx_23060236_icache_refill_if.sv
// Bus bundle for the I-cache refill controller: IFU miss request/response,
// cache-array write port, fence.i, and the AXI4 read address/data channels.
// The master modport is the refill controller; the slave modport is its
// environment (IFU, cache array and memory).
interface ysyx_23060236_icache_refill_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);
    // IFU side
    logic                req_valid;
    logic                req_ready;
    logic [ADDR_LEN-1:0] req_addr;
    logic                resp_valid;
    logic [DATA_LEN-1:0] resp_data;
    logic                resp_err;
    // Cache array write port
    logic [ADDR_LEN-1:0] icache_awaddr;
    logic [DATA_LEN-1:0] icache_wdata;
    logic                icache_wvalid;
    logic                inst_fencei;
    // AXI4 read address channel
    logic                arvalid;
    logic                arready;
    logic [ADDR_LEN-1:0] araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    // AXI4 read data channel
    logic                rvalid;
    logic                rready;
    logic [DATA_LEN-1:0] rdata;
    logic [1:0]          rresp;
    logic                rlast;

    modport master (
        input  req_valid, req_addr, inst_fencei,
        input  arready, rvalid, rdata, rresp, rlast,
        output req_ready, resp_valid, resp_data, resp_err,
        output icache_awaddr, icache_wdata, icache_wvalid,
        output arvalid, araddr, arlen, arsize, arburst, rready
    );

    modport slave (
        output req_valid, req_addr, inst_fencei,
        output arready, rvalid, rdata, rresp, rlast,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  icache_awaddr, icache_wdata, icache_wvalid,
        input  arvalid, araddr, arlen, arsize, arburst, rready
    );
endinterface

// File: rtl/ysyx_23060236_icache_refill.sv
// I-cache miss refill controller: one AXI4 read burst fills a local line
// buffer, then the line is written into the cache array word by word and
// the missed instruction is returned to the IFU. A bus error or a fence.i
// seen during the burst suppresses the array write so no partial or stale
// line is ever installed.
// Optional macro ICACHE_CRITWORD_EN: WRAP burst starting at the missed word,
// with the IFU response issued right after the first beat.
module ysyx_23060236_icache_refill #(
    parameter int ADDR_LEN   = 32,
    parameter int DATA_LEN   = 32,
    parameter int OFFSET_LEN = 5
) (
    input logic                           clock,
    input logic                           reset,
    ysyx_23060236_icache_refill_if.master bus
);
    localparam int IDX_W = OFFSET_LEN - 2;
    localparam int WORDS = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] LAST = '1;

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_DONE} state_t;

    state_t              r_state;
    logic [ADDR_LEN-1:0] r_line_addr;
    logic [IDX_W-1:0]    r_word;
    logic [IDX_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_wcnt;
    logic                r_err;
    logic                r_discard;
    logic                r_ovf;
    logic [DATA_LEN-1:0] r_buf [WORDS];

    logic                r_req_ready;
    logic                r_resp_valid;
    logic [DATA_LEN-1:0] r_resp_data;
    logic                r_resp_err;
    logic [ADDR_LEN-1:0] r_awaddr;
    logic [DATA_LEN-1:0] r_wdata;
    logic                r_wvalid;
    logic                r_arvalid;
    logic [ADDR_LEN-1:0] r_araddr;
    logic [7:0]          r_arlen;
    logic [2:0]          r_arsize;
    logic [1:0]          r_arburst;
    logic                r_rready;

    logic [ADDR_LEN-1:0] w_req_line;
    logic [IDX_W-1:0]    w_req_word;
    logic [IDX_W-1:0]    w_beat_idx;
    logic                w_beat_err;
    logic                w_len_err;
    logic                w_err_n;
    logic                w_disc_n;
    logic [DATA_LEN-1:0] w_word_data;
    logic [DATA_LEN-1:0] w_buf0;
    logic [IDX_W-1:0]    w_wnext;
    logic                w_unused;

    assign w_req_line = {bus.req_addr[ADDR_LEN-1:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
    assign w_req_word = bus.req_addr[OFFSET_LEN-1:2];
    assign w_unused   = &{1'b0, bus.req_addr[1:0]};

`ifdef ICACHE_CRITWORD_EN
    // Wrapping burst starts at the missed word, so beat k lands at word+k.
    assign w_beat_idx = r_cnt + r_word;
`else
    assign w_beat_idx = r_cnt;
`endif

    // A short burst (rlast early) or a long one (no rlast on the 8th beat)
    // both leave the line untrustworthy.
    assign w_beat_err = (bus.rresp != 2'b00);
    assign w_len_err  = bus.rlast ? (r_cnt != LAST) : (r_cnt == LAST);
    assign w_err_n    = r_err | w_beat_err | w_len_err;
    assign w_disc_n   = r_discard | bus.inst_fencei;

    // The buffer entry may be written on the same edge it is read out, so
    // forward the incoming beat when the indices coincide.
    assign w_word_data = (!r_ovf && w_beat_idx == r_word) ? bus.rdata : r_buf[r_word];
    assign w_buf0      = (!r_ovf && w_beat_idx == '0) ? bus.rdata : r_buf[0];
    assign w_wnext     = r_wcnt + 1'b1;

    // Line buffer capture; surplus beats after an overlong burst are dropped.
    always_ff @(posedge clock) begin
        if (r_state == S_R && bus.rvalid && !r_ovf) begin
            r_buf[w_beat_idx] <= bus.rdata;
        end
    end

    // Refill FSM with all bus outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_line_addr  <= '0;
            r_word       <= '0;
            r_cnt        <= '0;
            r_wcnt       <= '0;
            r_err        <= 1'b0;
            r_discard    <= 1'b0;
            r_ovf        <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_awaddr     <= '0;
            r_wdata      <= '0;
            r_wvalid     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arsize     <= '0;
            r_arburst    <= '0;
            r_rready     <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_line_addr <= w_req_line;
                        r_word      <= w_req_word;
                        r_cnt       <= '0;
                        r_err       <= 1'b0;
                        r_discard   <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_req_ready <= 1'b0;
                        r_arvalid   <= 1'b1;
                        r_arlen     <= 8'(WORDS - 1);
                        r_arsize    <= 3'b010;
`ifdef ICACHE_CRITWORD_EN
                        r_araddr    <= {bus.req_addr[ADDR_LEN-1:2], 2'b00};
                        r_arburst   <= 2'b10;
`else
                        r_araddr    <= w_req_line;
                        r_arburst   <= 2'b01;
`endif
                        r_state     <= S_AR;
                    end
                end
                S_AR: begin
                    if (bus.inst_fencei) r_discard <= 1'b1;
                    if (bus.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (bus.rvalid) begin
                        r_cnt     <= r_cnt + 1'b1;
                        r_err     <= w_err_n;
                        r_discard <= w_disc_n;
                        if (!bus.rlast && r_cnt == LAST) r_ovf <= 1'b1;
`ifdef ICACHE_CRITWORD_EN
                        if (r_cnt == '0 && !r_ovf) begin
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= bus.rdata;
                            r_resp_err   <= w_beat_err;
                        end
`endif
                        if (bus.rlast) begin
                            r_rready <= 1'b0;
                            if (!w_err_n && !w_disc_n) begin
                                r_wcnt   <= '0;
                                r_wvalid <= 1'b1;
                                r_awaddr <= r_line_addr;
                                r_wdata  <= w_buf0;
                                r_state  <= S_WR;
                            end else begin
`ifndef ICACHE_CRITWORD_EN
                                r_resp_valid <= 1'b1;
                                r_resp_data  <= w_word_data;
                                r_resp_err   <= w_err_n & ~w_disc_n;
`endif
                                r_state      <= S_DONE;
                            end
                        end
                    end else if (bus.inst_fencei) begin
                        r_discard <= 1'b1;
                    end
                end
                S_WR: begin
                    // fence.i clears the array on this edge, overriding the
                    // write in flight, so stop writing immediately.
                    if (bus.inst_fencei || r_wcnt == LAST) begin
                        r_wvalid     <= 1'b0;
`ifndef ICACHE_CRITWORD_EN
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= r_buf[r_word];
                        r_resp_err   <= 1'b0;
`endif
                        r_state      <= S_DONE;
                    end else begin
                        r_wcnt   <= w_wnext;
                        r_awaddr <= r_line_addr | {{(ADDR_LEN-OFFSET_LEN){1'b0}}, w_wnext, 2'b00};
                        r_wdata  <= r_buf[w_wnext];
                    end
                end
                S_DONE: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_data     = r_resp_data;
    assign bus.resp_err      = r_resp_err;
    assign bus.icache_awaddr = r_awaddr;
    assign bus.icache_wdata  = r_wdata;
    assign bus.icache_wvalid = r_wvalid;
    assign bus.arvalid       = r_arvalid;
    assign bus.araddr        = r_araddr;
    assign bus.arlen         = r_arlen;
    assign bus.arsize        = r_arsize;
    assign bus.arburst       = r_arburst;
    assign bus.rready        = r_rready;
endmodule

// File: tb/tb_ysyx_23060236_icache_refill.sv
// Directed bench for the I-cache refill controller: a table of refill
// scenarios driven through a small AXI memory model, plus hand-written
// reset and idle fence.i sequences.
module tb_ysyx_23060236_icache_refill;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ysyx_23060236_icache_refill_if bus();

    ysyx_23060236_icache_refill dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] base;
        int          ar_stall;
        int          r_seed;
        int          nbeats;
        int          err_beat;
        int          fence_beat;
        int          fence_wr;
        int          exp_writes;
        logic        exp_err;
        bit          chk_lat;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int stall_len(input int seed, input int k);
        return (seed == 0) ? 0 : ((k * seed + 1) % 6);
    endfunction

    task automatic drive_idle();
        bus.req_valid   = 1'b0;
        bus.req_addr    = '0;
        bus.inst_fencei = 1'b0;
        bus.arready     = 1'b0;
        bus.rvalid      = 1'b0;
        bus.rdata       = '0;
        bus.rresp       = 2'b00;
        bus.rlast       = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  32'(bus.req_ready), 32'd1);
        chk({tag, "_arvalid"},    32'(bus.arvalid), 32'd0);
        chk({tag, "_araddr"},     bus.araddr, 32'd0);
        chk({tag, "_arlen"},      32'(bus.arlen), 32'd0);
        chk({tag, "_rready"},     32'(bus.rready), 32'd0);
        chk({tag, "_wvalid"},     32'(bus.icache_wvalid), 32'd0);
        chk({tag, "_awaddr"},     bus.icache_awaddr, 32'd0);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_resp_data"},  bus.resp_data, 32'd0);
    endtask

    // One full refill: request, AXI memory model, write and response checks.
    task automatic run_vec(input int id, input vec_t v);
        logic [31:0] line;
        logic [2:0]  word;
        logic [31:0] exp_araddr;
        logic [1:0]  exp_burst;
        logic        exp_err;
        logic [2:0]  start_off;
        int ar_wait, r_wait, beat, nw, n_resp, beat0_it;
        bit ar_done, ar_hs, r_hs, done;
        string tag;
        tag = $sformatf("v%0d", id);
        line = {v.addr[31:5], 5'b0};
        word = v.addr[4:2];
`ifdef ICACHE_CRITWORD_EN
        exp_araddr = {v.addr[31:2], 2'b00};
        exp_burst  = 2'b10;
        exp_err    = (v.err_beat == 0);
`else
        exp_araddr = line;
        exp_burst  = 2'b01;
        exp_err    = v.exp_err;
`endif
        ar_wait = v.ar_stall; r_wait = stall_len(v.r_seed, 0);
        beat = 0; nw = 0; n_resp = 0; beat0_it = 0; start_off = 3'd0;
        ar_done = 0; done = 0;

        @(negedge clock);
        chk({tag, "_ready_idle"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = v.addr;
        for (int it = 1; it <= 400 && !done; it++) begin
            @(negedge clock);
            drive_idle();
            ar_hs = 0; r_hs = 0;
            if (it == 1) chk({tag, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
            if (bus.arvalid) begin
                chk({tag, "_araddr"},  bus.araddr, exp_araddr);
                chk({tag, "_arlen"},   32'(bus.arlen), 32'd7);
                chk({tag, "_arsize"},  32'(bus.arsize), 32'd2);
                chk({tag, "_arburst"}, 32'(bus.arburst), 32'(exp_burst));
                if (ar_wait > 0) ar_wait--;
                else begin
                    bus.arready = 1'b1;
                    ar_hs = 1;
                    start_off = exp_araddr[4:2];
                end
            end
            if (ar_done && beat < v.nbeats) begin
                if (r_wait > 0) r_wait--;
                else begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = (beat < 8) ? v.base + 32'((start_off + 3'(beat))) : 32'hDEAD_0000 + 32'(beat);
                    bus.rresp  = (beat == v.err_beat) ? 2'b10 : 2'b00;
                    bus.rlast  = (beat == v.nbeats - 1);
                    if (beat == v.fence_beat) bus.inst_fencei = 1'b1;
                    if (bus.rready) begin
                        r_hs = 1;
                        if (beat == 0) beat0_it = it;
                    end
                end
            end
            if (bus.icache_wvalid) begin
                chk({tag, "_awaddr"}, bus.icache_awaddr, line + 32'(4 * nw));
                chk({tag, "_wdata"},  bus.icache_wdata, v.base + 32'(nw));
`ifndef ICACHE_CRITWORD_EN
                if (v.chk_lat && nw == 0) chk({tag, "_wr_latency"}, 32'(it), 32'd10);
`endif
                if (nw == v.fence_wr) bus.inst_fencei = 1'b1;
                nw++;
            end
            if (bus.resp_valid) begin
                n_resp++;
                chk({tag, "_resp_data"}, bus.resp_data, v.base + 32'(word));
                chk({tag, "_resp_err"},  32'(bus.resp_err), 32'(exp_err));
`ifdef ICACHE_CRITWORD_EN
                chk({tag, "_resp_after_beat0"}, 32'(it), 32'(beat0_it + 1));
`else
                if (v.chk_lat) chk({tag, "_resp_latency"}, 32'(it), 32'd18);
`endif
            end
            if (it > 1 && bus.req_ready) done = 1;
            if (ar_hs) ar_done = 1;
            if (r_hs) begin
                beat++;
                r_wait = stall_len(v.r_seed, beat);
            end
        end
        chk({tag, "_finished"}, 32'(done), 32'd1);
        chk({tag, "_resp_count"}, 32'(n_resp), 32'd1);
        chk({tag, "_write_count"}, 32'(nw), 32'(v.exp_writes));
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        #1;
        chk_reset_outputs("por");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        //        addr          base     ars rs nb err fb fw  ew err lat
        vecs[0] = '{32'h8000_0014, 32'h100, 0, 0, 8,  -1, -1, -1, 8, 1'b0, 1'b1};
        vecs[1] = '{32'h8000_0014, 32'h100, 3, 5, 8,  -1, -1, -1, 8, 1'b0, 1'b0};
        vecs[2] = '{32'h8000_0040, 32'h200, 0, 0, 8,   3, -1, -1, 0, 1'b1, 1'b0};
        vecs[3] = '{32'h8000_0068, 32'h300, 0, 2, 8,  -1,  5, -1, 0, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0084, 32'h400, 0, 0, 8,  -1, -1,  2, 3, 1'b0, 1'b0};
        vecs[5] = '{32'h8000_00A0, 32'h500, 1, 0, 6,  -1, -1, -1, 0, 1'b1, 1'b0};
        vecs[6] = '{32'h8000_00D8, 32'h600, 0, 1, 10, -1, -1, -1, 0, 1'b1, 1'b0};
        vecs[7] = '{32'h8000_001C, 32'h700, 2, 3, 8,  -1, -1, -1, 8, 1'b0, 1'b0};

        // fence.i while idle must not disturb anything
        @(negedge clock);
        bus.inst_fencei = 1'b1;
        @(negedge clock);
        bus.inst_fencei = 1'b0;
        chk("idle_fence_ready",  32'(bus.req_ready), 32'd1);
        chk("idle_fence_wvalid", 32'(bus.icache_wvalid), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset in the middle of the R phase
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8000_0100;
        @(negedge clock);
        drive_idle();
        chk("rst_seq_arvalid", 32'(bus.arvalid), 32'd1);
        bus.arready = 1'b1;
        @(negedge clock);
        drive_idle();
        chk("rst_seq_rready", 32'(bus.rready), 32'd1);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h0000_0AAA;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("midr");
        @(negedge clock);
        drive_idle();
        reset = 1'b0;

        run_vec(8, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
